// File: rtl/encoder_pkg.sv
// Shared types and opcode constants for the RV32 instruction encoder.
// opcode_fits() backs the optional ENCODER_CHECK_EN opcode/format check.
package encoder_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_U   = 2'd2,
      FMT_BAD = 2'd3
   } fmt_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // True when op is a 32-bit opcode belonging to the class implied by f.
   function automatic logic opcode_fits(input fmt_e f, input logic [6:0] op);
      logic ok;
      if (op[1:0] != 2'b11) begin
         ok = 1'b0;
      end else begin
         case (f)
            FMT_R:   ok = (op == OP_REG);
            FMT_I:   ok = (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JALR);
            FMT_U:   ok = (op == OP_LUI) || (op == OP_AUIPC);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: field bundle + format -> 32-bit RV32 word and a legality flag.
// With ENCODER_CHECK_EN defined, opcodes that do not match the format are flagged illegal.
module instr_pack
   import encoder_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rs1,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [6:0]  opcode,
   input  logic [11:0] imm_i,
   input  logic [19:0] imm_u,
   output logic [31:0] word,
   output logic        legal
);

   // Field placement mirrors the decoder so the word decodes back to its fields.
   always_comb begin
      word  = 32'h0000_0000;
      legal = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: begin
            word  = {funct7, rs2, rs1, funct3, rd, opcode};
            legal = 1'b1;
         end
         FMT_I: begin
            word  = {imm_i, rs1, funct3, rd, opcode};
            legal = 1'b1;
         end
         FMT_U: begin
            word  = {imm_u, rd, opcode};
            legal = 1'b1;
         end
         default: begin
            word  = 32'h0000_0000;
            legal = 1'b0;
         end
      endcase
`ifdef ENCODER_CHECK_EN
      if (!opcode_fits(fmt_e'(fmt), opcode)) begin
         legal = 1'b0;
      end else begin
         legal = legal;
      end
`endif
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV32 words into instruction memory with an auto-incrementing address.
// Optional opcode/format checking is enabled by defining ENCODER_CHECK_EN.
module instr_encoder
   import encoder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        fmt,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rs2,
   input  logic [4:0]        rs1,
   input  logic [2:0]        funct3,
   input  logic [4:0]        rd,
   input  logic [6:0]        opcode,
   input  logic [11:0]       imm_i,
   input  logic [19:0]       imm_u,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

   state_e              state_r;
   state_e              next_state_s;
   logic [ADDR_W-1:0]   wptr_r;
   logic [ADDR_W:0]     count_r;
   logic                err_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [31:0]         mem_wdata_r;
   logic                done_r;
   logic                ready_s;
   logic                accept_s;
   logic [31:0]         word_s;
   logic                legal_s;

   instr_pack u_pack (
      .fmt    (fmt),
      .funct7 (funct7),
      .rs2    (rs2),
      .rs1    (rs1),
      .funct3 (funct3),
      .rd     (rd),
      .opcode (opcode),
      .imm_i  (imm_i),
      .imm_u  (imm_u),
      .word   (word_s),
      .legal  (legal_s)
   );

   // Ready only while loading and the session has not yet filled the memory.
   always_comb begin
      ready_s = 1'b0;
      if ((state_r == LOAD) && (count_r < CAPACITY)) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
   end

   assign accept_s = in_valid && ready_s;

   // Next-state logic; a bundle offered at full capacity ends the session as overflow.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = LOAD;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOAD: begin
            if (accept_s && in_last) begin
               next_state_s = DRAIN;
            end else if (in_valid && !ready_s) begin
               next_state_s = DRAIN;
            end else begin
               next_state_s = LOAD;
            end
         end
         DRAIN:   next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, counters, sticky error and the registered write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         wptr_r      <= {ADDR_W{1'b0}};
         count_r     <= {(ADDR_W+1){1'b0}};
         err_r       <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= 32'h0000_0000;
         done_r      <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         mem_we_r <= 1'b0;
         done_r   <= (state_r == LOAD) && (next_state_s == DRAIN);
         if ((state_r == IDLE) && start) begin
            wptr_r  <= base_addr;
            count_r <= {(ADDR_W+1){1'b0}};
            err_r   <= 1'b0;
         end else if (accept_s) begin
            if (legal_s) begin
               mem_we_r    <= 1'b1;
               mem_addr_r  <= wptr_r;
               mem_wdata_r <= word_s;
               wptr_r      <= wptr_r + ADDR_W'(1);
               count_r     <= count_r + (ADDR_W+1)'(1);
            end else begin
               err_r <= 1'b1;
            end
         end else if ((state_r == LOAD) && in_valid) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign in_ready  = ready_s;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign busy      = (state_r != IDLE);
   assign done      = done_r;
   assign count     = count_r;
   assign err       = err_r;

endmodule
